// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment bus: digit codes, active-low segment
// patterns (g..a) and capture FSM encodings.
package seven_seg_pkg;

  localparam logic [3:0] CODE_BLANK   = 4'd10;
  localparam logic [3:0] CODE_INVALID = 4'd15;

  // Active-low patterns, bit 6 = g .. bit 0 = a; the transmit driver uses these too.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

endpackage

// File: rtl/seven_seg_capture_decode.sv
// Combinational map from an active-low segment pattern back to a digit code.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code
);

  always_comb begin
    case (i_seg)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_BLANK: o_code = CODE_BLANK;
      default:   o_code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a scanned seven-segment bus: registers the pins,
// waits for a stable tuple, decodes it and holds one code per digit.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NUM_DIGITS-1:0]   i_an,
  input  logic [6:0]              i_seg,
  input  logic                    i_dp,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_dps,
  output logic                    o_frame_done,
  output logic [7:0]              o_frame_count,
  output logic                    o_scan_error,
  output logic                    o_stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ZW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_new;
  logic [CW-1:0]           r_cnt;
  logic [1:0]              r_state;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dps;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [7:0]              r_frame_cnt;
  logic                    r_frame_done;
  logic                    r_scan_err;
  logic [TW-1:0]           r_to_cnt;

  logic                    w_same;
  logic                    w_idle;
  logic [ZW-1:0]           w_nlow;
  logic                    w_fire;
  logic                    w_latch;
  logic                    w_multi;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;
  logic                    w_frame;
  logic [1:0]              w_state_nxt;
  logic [3:0]              w_code;

  seg_pattern_decode u_decode (
    .i_seg  (r_seg),
    .o_code (w_code)
  );

  assign w_same = ({i_an, i_seg, i_dp} == {r_an, r_seg, r_dp});
  assign w_idle = &r_an;
  assign w_sel  = ~r_an;

  always_comb begin
    w_nlow = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!r_an[i]) w_nlow = w_nlow + ZW'(1);
  end

  // A fresh tuple may fire immediately when it only needs one sample to be stable.
  assign w_fire     = !w_idle && (r_cnt == STAB_MAX) && (r_state == ST_DWELL || r_new);
  assign w_latch    = w_fire && (w_nlow == ZW'(1));
  assign w_multi    = w_fire && (w_nlow > ZW'(1));
  assign w_seen_nxt = r_seen | w_sel;
  assign w_frame    = w_latch && (&w_seen_nxt);

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire)
      w_state_nxt = ST_HELD;
    else if (r_new || r_state == ST_IDLE)
      w_state_nxt = w_idle ? ST_IDLE : ST_DWELL;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_an         <= '1;
      r_seg        <= '1;
      r_dp         <= 1'b1;
      r_new        <= 1'b0;
      r_cnt        <= '0;
      r_state      <= ST_IDLE;
      r_digits     <= {NUM_DIGITS{CODE_BLANK}};
      r_dps        <= '0;
      r_seen       <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_scan_err   <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_an         <= i_an;
      r_seg        <= i_seg;
      r_dp         <= i_dp;
      r_new        <= !w_same;
      r_cnt        <= !w_same ? CW'(1) : (r_cnt == STAB_MAX) ? r_cnt : r_cnt + CW'(1);
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame;
      r_scan_err   <= w_multi;
      if (w_latch) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (w_sel[i]) begin
            r_digits[4*i +: 4] <= w_code;
            r_dps[i]           <= ~r_dp;
          end
        r_seen <= w_frame ? '0 : w_seen_nxt;
        if (w_frame) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      // Latch beats saturation when both land on the same edge.
      if (w_latch)                r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign o_digits      = r_digits;
  assign o_dps         = r_dps;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_cnt;
  assign o_scan_error  = r_scan_err;
  assign o_stale       = (r_to_cnt == TO_MAX);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed steps then random scanning, checked
// every cycle against a run-length reference model of the bus.
module tb_seven_seg_capture;

  localparam int STABLE  = 2;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] o_digits;
  logic [3:0]  o_dps;
  logic        o_frame_done;
  logic [7:0]  o_frame_count;
  logic        o_scan_error;
  logic        o_stale;

  always #5 clk = ~clk;

  seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_an          (an),
    .i_seg         (seg),
    .i_dp          (dp),
    .o_digits      (o_digits),
    .o_dps         (o_dps),
    .o_frame_done  (o_frame_done),
    .o_frame_count (o_frame_count),
    .o_scan_error  (o_scan_error),
    .o_stale       (o_stale)
  );

  int checks = 0;
  int errors = 0;
  int se_pulses = 0;
  int fd_pulses = 0;
  bit saw_one = 0;

  logic [6:0] tbl [0:10];
  initial begin
    tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
    tbl[4] = 7'b0011001; tbl[5] = 7'b0010010; tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
    tbl[8] = 7'b0000000; tbl[9] = 7'b0010000; tbl[10] = 7'b1111111;
  end

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i <= 10; i++)
      if (s == tbl[i]) return 4'(i);
    return 4'd15;
  endfunction

  // Reference: a run of identical samples starting at edge r is acted on at edge r+STABLE.
  logic [11:0] m_s;
  int          m_k = 0, m_rstart = 0, m_quiet = 0;
  logic [15:0] e_digits;
  logic [3:0]  e_dps, m_seen;
  logic [7:0]  e_fc;
  logic        e_fd, e_se, e_stale;

  always @(posedge clk) begin : model
    int nlow, idx;
    bit latched;
    m_k = m_k + 1;
    e_fd = 0; e_se = 0; latched = 0;
    if (rst) begin
      m_s = 12'hFFF; m_rstart = m_k; m_quiet = 0;
      e_digits = 16'hAAAA; e_dps = 0; m_seen = 0; e_fc = 0; e_stale = 0;
    end else begin
      if (m_s[11:8] != 4'hF && (m_k - m_rstart) == STABLE) begin
        nlow = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!m_s[8+i]) begin nlow++; idx = i; end
        if (nlow == 1) begin
          e_digits[4*idx +: 4] = ref_decode(m_s[7:1]);
          e_dps[idx] = ~m_s[0];
          m_seen[idx] = 1'b1;
          latched = 1;
          if (m_seen == 4'hF) begin e_fd = 1; m_seen = 0; e_fc = e_fc + 8'd1; end
        end else e_se = 1;
      end
      if (latched) m_quiet = 0;
      else if (m_quiet < TIMEOUT) m_quiet++;
      e_stale = (m_quiet == TIMEOUT);
      if ({an, seg, dp} != m_s) begin m_s = {an, seg, dp}; m_rstart = m_k; end
    end
  end

  task automatic check_outputs();
    checks++;
    assert (o_digits === e_digits) else begin errors++; $error("FAIL digits obs=%h exp=%h t=%0t", o_digits, e_digits, $time); end
    checks++;
    assert (o_dps === e_dps) else begin errors++; $error("FAIL dps obs=%b exp=%b t=%0t", o_dps, e_dps, $time); end
    checks++;
    assert (o_frame_done === e_fd) else begin errors++; $error("FAIL frame_done obs=%b exp=%b t=%0t", o_frame_done, e_fd, $time); end
    checks++;
    assert (o_frame_count === e_fc) else begin errors++; $error("FAIL frame_count obs=%0d exp=%0d t=%0t", o_frame_count, e_fc, $time); end
    checks++;
    assert (o_scan_error === e_se) else begin errors++; $error("FAIL scan_error obs=%b exp=%b t=%0t", o_scan_error, e_se, $time); end
    checks++;
    assert (o_stale === e_stale) else begin errors++; $error("FAIL stale obs=%b exp=%b t=%0t", o_stale, e_stale, $time); end
    if (o_scan_error === 1'b1) se_pulses++;
    if (o_frame_done === 1'b1) fd_pulses++;
    if (o_digits[7:4] === 4'd1) saw_one = 1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin : stim
    logic [15:0] saved;
    logic [3:0]  ra;
    logic [6:0]  rs;
    int          sel;
    rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
    drive(4'hF, 7'h7F, 1'b1, 2);
    checks++;
    assert (o_digits === 16'hAAAA && o_dps === 4'h0 && o_frame_count === 8'd0 &&
            {o_frame_done, o_scan_error, o_stale} === 3'b000)
      else begin errors++; $error("FAIL reset obs=%h/%b/%0d exp=aaaa/0/0", o_digits, o_dps, o_frame_count); end
    rst = 1'b0;

    // Latency: not yet visible after two edges, visible on the third.
    drive(4'b1110, 7'b0100100, 1'b0, 2);
    checks++;
    assert (o_digits[3:0] === 4'hA) else begin errors++; $error("FAIL early_latch obs=%h exp=a", o_digits[3:0]); end
    drive(4'b1110, 7'b0100100, 1'b0, 1);
    checks++;
    assert (o_digits[3:0] === 4'd2 && o_dps[0] === 1'b1)
      else begin errors++; $error("FAIL latch2 obs=%h/%b exp=2/1", o_digits[3:0], o_dps[0]); end

    fd_pulses = 0;
    drive(4'b1110, tbl[1], 1'b1, 4);
    drive(4'b1101, tbl[2], 1'b1, 4);
    drive(4'b0111, tbl[3], 1'b1, 4);
    drive(4'b1011, tbl[4], 1'b1, 4);
    checks++;
    assert (fd_pulses == 1 && o_frame_count === 8'd1 && o_digits === 16'h3421)
      else begin errors++; $error("FAIL frame obs=%0d/%0d/%h exp=1/1/3421", fd_pulses, o_frame_count, o_digits); end

    saw_one = 0;
    drive(4'b1101, tbl[1], 1'b1, 1);
    drive(4'b1101, tbl[3], 1'b1, 3);
    checks++;
    assert (o_digits[7:4] === 4'd3 && !saw_one)
      else begin errors++; $error("FAIL glitch obs=%h saw1=%0d exp=3 saw1=0", o_digits[7:4], saw_one); end

    saved = o_digits; se_pulses = 0;
    drive(4'b1100, tbl[8], 1'b1, 3);
    drive(4'hF, 7'h7F, 1'b1, 2);
    checks++;
    assert (se_pulses == 1 && o_digits === saved)
      else begin errors++; $error("FAIL scan_err obs=%0d/%h exp=1/%h", se_pulses, o_digits, saved); end

    drive(4'b1110, 7'b1010101, 1'b1, 3);
    checks++;
    assert (o_digits[3:0] === 4'hF) else begin errors++; $error("FAIL invalid obs=%h exp=f", o_digits[3:0]); end
    drive(4'hF, 7'h7F, 1'b1, 1000);
    checks++;
    assert (o_stale === 1'b0) else begin errors++; $error("FAIL stale_early obs=%b exp=0", o_stale); end
    drive(4'hF, 7'h7F, 1'b1, 30);
    checks++;
    assert (o_stale === 1'b1 && o_digits[3:0] === 4'hF)
      else begin errors++; $error("FAIL stale_set obs=%b/%h exp=1/f", o_stale, o_digits[3:0]); end
    drive(4'b1110, tbl[5], 1'b0, 3);
    checks++;
    assert (o_stale === 1'b0 && o_digits[3:0] === 4'd5)
      else begin errors++; $error("FAIL stale_clr obs=%b/%h exp=0/5", o_stale, o_digits[3:0]); end

    // Random scanning: glitches, idle gaps, multi-anode faults and junk patterns.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 5));
      if (sel < 4)       ra = ~(4'b0001 << sel);
      else if (sel == 4) ra = 4'hF;
      else               ra = 4'($urandom);
      rs = ($urandom_range(0, 1) == 1) ? tbl[$urandom_range(0, 10)] : 7'($urandom);
      drive(ra, rs, 1'($urandom), int'($urandom_range(1, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
